// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared I/O page offsets and timer control bit positions
package dmem_mmio_pkg;

   localparam logic [7:0] IO_LED    = 8'd0;
   localparam logic [7:0] IO_SW     = 8'd1;
   localparam logic [7:0] IO_TCTRL  = 8'd2;
   localparam logic [7:0] IO_TLOAD  = 8'd3;
   localparam logic [7:0] IO_TCOUNT = 8'd4;
   localparam logic [7:0] IO_CYCLE  = 8'd5;

   localparam int TCTRL_EN         = 0;
   localparam int TCTRL_AUTORELOAD = 1;
   localparam int TCTRL_TFLAG      = 2;
   localparam int TCTRL_IRQEN      = 3;

endpackage

// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - prescaled down-counter with reload, sticky flag and interrupt
module dmem_timer
   import dmem_mmio_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_tctrl,
   input  logic        wr_tload,
   input  logic        wr_tcount,
   input  logic [15:0] wdata,
   output logic [15:0] tctrl,
   output logic [15:0] tload,
   output logic [15:0] tcount,
   output logic        timer_irq
);

   logic        en;
   logic        autoreload;
   logic        irqen;
   logic        tflag;
   logic [15:0] presc;
   logic        tick;
   logic        expire;

   assign tick   = en && (presc == 16'(PRESCALE - 1));
   assign expire = tick && (tcount == 16'd1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         en         <= 1'b0;
         autoreload <= 1'b0;
         irqen      <= 1'b0;
         tflag      <= 1'b0;
         presc      <= '0;
         tload      <= '0;
         tcount     <= '0;
      end else begin
         // any control write restarts the prescale period from zero
         if (wr_tctrl || !en || tick) presc <= '0;
         else                         presc <= presc + 16'd1;

         if (wr_tctrl) begin
            en         <= wdata[TCTRL_EN];
            autoreload <= wdata[TCTRL_AUTORELOAD];
            irqen      <= wdata[TCTRL_IRQEN];
         end

         if (expire)                             tflag <= 1'b1;
         else if (wr_tctrl && wdata[TCTRL_TFLAG]) tflag <= 1'b0;

         if (wr_tload) tload <= wdata;

         if (wr_tcount)                        tcount <= wdata;
         else if (expire)                      tcount <= autoreload ? tload : 16'd0;
         else if (tick && (tcount != 16'd0))   tcount <= tcount - 16'd1;
      end
   end

   always_comb begin
      tctrl                   = '0;
      tctrl[TCTRL_EN]         = en;
      tctrl[TCTRL_AUTORELOAD] = autoreload;
      tctrl[TCTRL_TFLAG]      = tflag;
      tctrl[TCTRL_IRQEN]      = irqen;
   end

   assign timer_irq = tflag & irqen;

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - CPU data-side RAM plus memory-mapped LED/switch/timer/cycle page
module dmem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int         RAM_WORDS = 240,
   parameter logic [7:0] IO_BASE   = 8'hF0,
   parameter int         PRESCALE  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  d_addr,
   input  logic        d_we,
   input  logic [15:0] d_dataout,
   output logic [15:0] d_datain,
   input  logic [15:0] sw,
   output logic [15:0] led,
   output logic        timer_irq
);

   logic [15:0] ram [RAM_WORDS];
   logic        ram_hit;
   logic        io_hit;
   logic [7:0]  io_off;
   logic [15:0] sw_meta;
   logic [15:0] sw_sync;
   logic [15:0] cycle;
   logic [15:0] tctrl;
   logic [15:0] tload;
   logic [15:0] tcount;
   logic        io_we;

   assign ram_hit = int'(d_addr) < RAM_WORDS;
   assign io_hit  = d_addr >= IO_BASE;
   assign io_off  = d_addr - IO_BASE;
   assign io_we   = d_we && io_hit;

   // RAM is not reset, but a write must never land while reset is held
   always_ff @(posedge clock) begin
      if (reset && d_we && ram_hit) ram[d_addr] <= d_dataout;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         led     <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
         cycle   <= '0;
      end else begin
         if (io_we && io_off == IO_LED) led <= d_dataout;
         sw_meta <= sw;
         sw_sync <= sw_meta;
         cycle   <= cycle + 16'd1;
      end
   end

   dmem_timer #(.PRESCALE(PRESCALE)) u_timer (
      .clock     (clock),
      .reset     (reset),
      .wr_tctrl  (io_we && io_off == IO_TCTRL),
      .wr_tload  (io_we && io_off == IO_TLOAD),
      .wr_tcount (io_we && io_off == IO_TCOUNT),
      .wdata     (d_dataout),
      .tctrl     (tctrl),
      .tload     (tload),
      .tcount    (tcount),
      .timer_irq (timer_irq)
   );

   always_comb begin
      d_datain = '0;
      if (ram_hit) begin
         d_datain = ram[d_addr];
      end else if (io_hit) begin
         case (io_off)
            IO_LED:    d_datain = led;
            IO_SW:     d_datain = sw_sync;
            IO_TCTRL:  d_datain = tctrl;
            IO_TLOAD:  d_datain = tload;
            IO_TCOUNT: d_datain = tcount;
            IO_CYCLE:  d_datain = cycle;
            default:   d_datain = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed and randomized checks of dmem_mmio against a behavioural model
module tb_dmem_mmio;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  d_addr = '0;
   logic        d_we = 1'b0;
   logic [15:0] d_dataout = '0;
   logic [15:0] d_datain;
   logic [15:0] sw = '0;
   logic [15:0] led;
   logic        timer_irq;

   logic [7:0]  d_addr4 = '0;
   logic        d_we4 = 1'b0;
   logic [15:0] d_dataout4 = '0;
   logic [15:0] d_datain4;
   logic [15:0] led4;
   logic        timer_irq4;

   int total = 0;
   int bad = 0;

   logic [15:0] mem_ref [256];
   bit          valid_ref [256];
   logic [15:0] led_ref = '0;
   logic [15:0] cyc_ref = '0;
   logic [15:0] sw_d1 = '0;
   logic [15:0] sw_d2 = '0;

   dmem_mmio dut (
      .clock(clock), .reset(reset), .d_addr(d_addr), .d_we(d_we),
      .d_dataout(d_dataout), .d_datain(d_datain), .sw(sw), .led(led),
      .timer_irq(timer_irq)
   );

   dmem_mmio #(.PRESCALE(4)) dut4 (
      .clock(clock), .reset(reset), .d_addr(d_addr4), .d_we(d_we4),
      .d_dataout(d_dataout4), .d_datain(d_datain4), .sw(sw), .led(led4),
      .timer_irq(timer_irq4)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) begin
         cyc_ref = cyc_ref + 16'd1;
         sw_d2 = sw_d1;
         sw_d1 = sw;
      end else begin
         cyc_ref = '0;
         sw_d1 = '0;
         sw_d2 = '0;
      end
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] v);
      if (reset) begin
         if (a < 8'd240) begin
            mem_ref[a] = v;
            valid_ref[a] = 1'b1;
         end else if (a == 8'hF0) begin
            led_ref = v;
         end
      end
      d_addr = a;
      d_dataout = v;
      d_we = 1'b1;
      tick();
      d_we = 1'b0;
   endtask

   task automatic chk(input logic [7:0] a, input logic [15:0] exp, input string tag);
      d_addr = a;
      d_we = 1'b0;
      #1;
      check(tag, d_datain, exp);
   endtask

   function automatic bit model_read(input logic [7:0] a, output logic [15:0] e);
      e = '0;
      if (a < 8'd240) begin
         e = mem_ref[a];
         return valid_ref[a];
      end
      case (a)
         8'hF0: e = led_ref;
         8'hF1: e = sw_d2;
         8'hF2, 8'hF3, 8'hF4: return 1'b0;
         8'hF5: e = cyc_ref;
         default: e = '0;
      endcase
      return 1'b1;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) valid_ref[i] = 1'b0;

      // reset state
      #1;
      check("rst_led", led, 16'h0000);
      check("rst_irq", {15'b0, timer_irq}, 16'h0000);
      chk(8'hF5, 16'h0000, "rst_cycle");
      chk(8'hF4, 16'h0000, "rst_tcount");
      tick();
      tick();
      reset = 1'b1;
      chk(8'hF5, 16'h0000, "cycle_start");
      tick();
      chk(8'hF5, 16'h0001, "cycle_one");

      // RAM and unmapped reads
      wr(8'h05, 16'h1234);
      chk(8'h05, 16'h1234, "ram_05");
      wr(8'hEA, 16'hBEEF);
      chk(8'hEA, 16'hBEEF, "ram_ea");
      chk(8'hF7, 16'h0000, "unmapped_f7");
      chk(8'hFF, 16'h0000, "unmapped_ff");

      // LED and switch synchroniser
      wr(8'hF0, 16'hA5A5);
      check("led_a5a5", led, 16'hA5A5);
      chk(8'hF0, 16'hA5A5, "led_read");
      wr(8'hF1, 16'hFFFF);
      chk(8'hF1, 16'h0000, "sw_ro");
      sw = 16'h00FF;
      chk(8'hF1, 16'h0000, "sw_edge0");
      tick();
      chk(8'hF1, 16'h0000, "sw_edge1");
      tick();
      chk(8'hF1, 16'h00FF, "sw_edge2");

      // one-shot timer
      wr(8'hF4, 16'd3);
      wr(8'hF2, 16'h0009);
      chk(8'hF4, 16'd3, "os_start");
      tick(); chk(8'hF4, 16'd2, "os_2");
      tick(); chk(8'hF4, 16'd1, "os_1");
      check("os_irq_low", {15'b0, timer_irq}, 16'h0000);
      tick(); chk(8'hF4, 16'd0, "os_0");
      chk(8'hF2, 16'h000D, "os_flag");
      check("os_irq", {15'b0, timer_irq}, 16'h0001);
      for (int i = 0; i < 5; i++) tick();
      chk(8'hF4, 16'd0, "os_hold");
      wr(8'hF2, 16'h000D);
      chk(8'hF2, 16'h0009, "os_clear");
      check("os_irq_clr", {15'b0, timer_irq}, 16'h0000);

      // auto-reload, and a TCOUNT write colliding with a tick
      wr(8'hF2, 16'h0000);
      wr(8'hF3, 16'd2);
      wr(8'hF4, 16'd2);
      wr(8'hF2, 16'h0003);
      chk(8'hF4, 16'd2, "ar_start");
      tick(); chk(8'hF4, 16'd1, "ar_1a");
      tick(); chk(8'hF4, 16'd2, "ar_reload");
      chk(8'hF2, 16'h0007, "ar_flag");
      check("ar_noirq", {15'b0, timer_irq}, 16'h0000);
      tick(); chk(8'hF4, 16'd1, "ar_1b");
      tick(); chk(8'hF4, 16'd2, "ar_2b");
      wr(8'hF4, 16'd7);
      chk(8'hF4, 16'd7, "ar_write_wins");
      tick(); chk(8'hF4, 16'd6, "ar_after_write");

      // flag set and write-1-clear on the same edge
      wr(8'hF2, 16'h0004);
      wr(8'hF4, 16'd2);
      wr(8'hF2, 16'h0001);
      chk(8'hF2, 16'h0001, "sc_noflag");
      tick(); chk(8'hF4, 16'd1, "sc_1");
      wr(8'hF2, 16'h0005);
      chk(8'hF2, 16'h0005, "sc_set_wins");
      chk(8'hF4, 16'd0, "sc_0");

      // prescale of 4
      d_addr4 = 8'hF4; d_dataout4 = 16'd3; d_we4 = 1'b1;
      tick();
      d_addr4 = 8'hF2; d_dataout4 = 16'h0001;
      tick();
      d_we4 = 1'b0; d_addr4 = 8'hF4;
      #1;
      check("p4_start", d_datain4, 16'd3);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("p4_count", d_datain4, 16'(3 - k / 4));
      end

      // asynchronous reset mid-count
      wr(8'hF0, 16'hFFFF);
      wr(8'h06, 16'h1111);
      wr(8'hF2, 16'h0004);
      wr(8'hF4, 16'd1);
      wr(8'hF2, 16'h0009);
      tick();
      check("pre_irq", {15'b0, timer_irq}, 16'h0001);
      wr(8'hF4, 16'd50);
      tick();
      chk(8'hF4, 16'd49, "pre_count");
      reset = 1'b0;
      led_ref = '0;
      #1;
      check("ar_led", led, 16'h0000);
      check("ar_irq", {15'b0, timer_irq}, 16'h0000);
      chk(8'hF4, 16'h0000, "ar_tcount");
      chk(8'hF5, 16'h0000, "ar_cycle");
      wr(8'h06, 16'hFFFF);
      wr(8'hF0, 16'h1234);
      check("ar_led_nowrite", led, 16'h0000);
      reset = 1'b1;
      chk(8'hF5, 16'h0000, "rel_cycle0");
      tick(); chk(8'hF5, 16'h0001, "rel_cycle1");
      tick(); chk(8'hF5, 16'h0002, "rel_cycle2");
      chk(8'h05, 16'h1234, "rel_ram05");
      chk(8'h06, 16'h1111, "rel_ram06");

      // randomized traffic against the model
      for (int i = 0; i < 120; i++) begin
         logic [7:0]  a;
         logic [15:0] v;
         logic [15:0] e;
         a = 8'($urandom_range(0, 255));
         v = 16'($urandom);
         if (a >= 8'hF2 && a <= 8'hF4) a = 8'hF0;
         if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            wr(a, v);
         end else begin
            if (model_read(a, e)) chk(a, e, "rand_read");
            chk(8'hF5, cyc_ref, "rand_cycle");
            chk(8'hF1, sw_d2, "rand_sw");
            tick();
         end
         check("rand_led", led, led_ref);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
